// File: rtl/scr1_reset_sequencer.sv
// Multi-domain reset generator: synchronise rst_n, hold, then release domains one at a time.
// Optional macro SCR1_RST_SEQ_ACK_EN gates each release on the previous domain's dom_ack.
module scr1_reset_sequencer #(
    parameter int unsigned N_DOMAINS   = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned RELEASE_DLY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 test_mode,
    input  logic                 test_rst_n,
    input  logic                 sw_rst_req,
    input  logic [N_DOMAINS-1:0] dom_en,
`ifdef SCR1_RST_SEQ_ACK_EN
    input  logic [N_DOMAINS-1:0] dom_ack,
`endif
    output logic [N_DOMAINS-1:0] rst_n_out,
    output logic [N_DOMAINS-1:0] rst_n_status,
    output logic                 seq_busy,
    output logic                 seq_done
);

    localparam int unsigned MaxCnt = (HOLD_CYCLES > RELEASE_DLY) ? HOLD_CYCLES : RELEASE_DLY;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = $clog2(N_DOMAINS + 1);
    localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYCLES);
    localparam logic [CntW-1:0] RelMax  = CntW'(RELEASE_DLY);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StHold,
        StRelease,
        StRun
    } state_e;

    logic                   w_rst_mux;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rst_sync;

    state_e                 r_state;
    logic [CntW-1:0]        r_hold_cnt;
    logic [CntW-1:0]        r_rel_cnt;
    logic [IdxW-1:0]        r_idx;
    logic [N_DOMAINS-1:0]   r_out;
    logic [N_DOMAINS-1:0]   r_status;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_found;
    logic                   w_more;
    logic [IdxW-1:0]        w_next;
    logic [N_DOMAINS-1:0]   w_first_oh;
    logic                   w_hold_exit;
    logic                   w_rel_go;
    logic                   w_rel_end;
    logic [N_DOMAINS-1:0]   w_rel_mask;
    logic                   w_ack_prev_ok;
    logic                   w_ack_all;

    assign w_rst_mux = test_mode ? test_rst_n : rst_n;

    always_ff @(posedge clk or negedge w_rst_mux) begin
        if (!w_rst_mux) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_rst_sync = r_sync[SYNC_STAGES-1];

`ifdef SCR1_RST_SEQ_ACK_EN
    localparam bit AckEn = 1'b1;

    logic [N_DOMAINS-1:0] r_ack_s1;
    logic [N_DOMAINS-1:0] r_ack_s2;
    logic [N_DOMAINS-1:0] r_prev_oh;

    always_ff @(posedge clk or negedge w_rst_mux) begin
        if (!w_rst_mux) begin
            r_ack_s1 <= '0;
            r_ack_s2 <= '0;
        end else begin
            r_ack_s1 <= dom_ack;
            r_ack_s2 <= r_ack_s1;
        end
    end

    // A domain disabled since its release no longer blocks the sequence.
    assign w_ack_prev_ok = ~|(r_prev_oh & dom_en & ~r_ack_s2);
    assign w_ack_all     = &(r_ack_s2 | ~dom_en);
`else
    localparam bit AckEn = 1'b0;

    assign w_ack_prev_ok = 1'b1;
    assign w_ack_all     = 1'b1;
`endif

    // Lowest enabled domain at or above the current index; disabled ones are skipped for free.
    always_comb begin
        w_found    = 1'b0;
        w_more     = 1'b0;
        w_next     = '0;
        w_first_oh = '0;
        for (int i = 0; i < N_DOMAINS; i++) begin
            if (dom_en[i] && (i >= int'(r_idx))) begin
                if (w_found) begin
                    w_more = 1'b1;
                end else begin
                    w_found       = 1'b1;
                    w_next        = IdxW'(i);
                    w_first_oh[i] = 1'b1;
                end
            end
        end
    end

    assign w_hold_exit = (r_state == StHold) && w_rst_sync && (r_hold_cnt == HoldMax);
    assign w_rel_go    = (r_state == StRelease) && w_found && (r_rel_cnt == RelMax) &&
                         w_ack_prev_ok;
    assign w_rel_end   = (r_state == StRelease) && !w_found && w_ack_all;
    assign w_rel_mask  = (w_hold_exit || w_rel_go) ? w_first_oh : '0;

    always_ff @(posedge clk or negedge w_rst_mux) begin
        if (!w_rst_mux) begin
            r_state    <= StHold;
            r_hold_cnt <= '0;
            r_rel_cnt  <= '0;
            r_idx      <= '0;
            r_out      <= '0;
            r_status   <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef SCR1_RST_SEQ_ACK_EN
            r_prev_oh  <= '0;
`endif
        end else begin
            r_status <= r_out;
            if (sw_rst_req) begin
                // The request edge itself counts as the first hold cycle once sync is out.
                r_state    <= StHold;
                r_hold_cnt <= w_rst_sync ? CntOne : '0;
                r_rel_cnt  <= '0;
                r_idx      <= '0;
                r_out      <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
`ifdef SCR1_RST_SEQ_ACK_EN
                r_prev_oh  <= '0;
`endif
            end else begin
                r_out <= (r_out & dom_en) | w_rel_mask;
                case (r_state)
                    StHold: begin
                        if (w_hold_exit) begin
                            r_rel_cnt <= CntOne;
                            r_idx     <= w_next + IdxW'(1);
`ifdef SCR1_RST_SEQ_ACK_EN
                            r_prev_oh <= w_first_oh;
`endif
                            if (w_found && (w_more || AckEn)) begin
                                r_state <= StRelease;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end else begin
                                r_state <= StRun;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else if (w_rst_sync && (r_hold_cnt != HoldMax)) begin
                            r_hold_cnt <= r_hold_cnt + CntOne;
                        end
                    end
                    StRelease: begin
                        if (w_rel_go) begin
                            r_rel_cnt <= CntOne;
                            r_idx     <= w_next + IdxW'(1);
`ifdef SCR1_RST_SEQ_ACK_EN
                            r_prev_oh <= w_first_oh;
`endif
                            if (w_more || AckEn) begin
                                r_state <= StRelease;
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end else begin
                                r_state <= StRun;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else if (w_rel_end) begin
                            r_state <= StRun;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_rel_cnt != RelMax) begin
                            r_rel_cnt <= r_rel_cnt + CntOne;
                        end
                    end
                    StRun: begin
                    end
                    default: begin
                        r_state <= StHold;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rst_n_out    = test_mode ? {N_DOMAINS{test_rst_n}} : r_out;
    assign rst_n_status = r_status;
    assign seq_busy     = r_busy;
    assign seq_done     = r_done;

endmodule
